// File: rtl/seg_scan_display_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver:
// segment bit positions and the hex-to-segment code table.
package seg_scan_display_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_DP = 7;

    localparam logic [6:0] HEX7_0 = 7'h3F;
    localparam logic [6:0] HEX7_1 = 7'h06;
    localparam logic [6:0] HEX7_2 = 7'h5B;
    localparam logic [6:0] HEX7_3 = 7'h4F;
    localparam logic [6:0] HEX7_4 = 7'h66;
    localparam logic [6:0] HEX7_5 = 7'h6D;
    localparam logic [6:0] HEX7_6 = 7'h7D;
    localparam logic [6:0] HEX7_7 = 7'h07;
    localparam logic [6:0] HEX7_8 = 7'h7F;
    localparam logic [6:0] HEX7_9 = 7'h6F;
    localparam logic [6:0] HEX7_A = 7'h77;
    localparam logic [6:0] HEX7_B = 7'h7C;
    localparam logic [6:0] HEX7_C = 7'h39;
    localparam logic [6:0] HEX7_D = 7'h5E;
    localparam logic [6:0] HEX7_E = 7'h79;
    localparam logic [6:0] HEX7_F = 7'h71;

    // Segment order {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: hex7 = HEX7_0;
            4'h1: hex7 = HEX7_1;
            4'h2: hex7 = HEX7_2;
            4'h3: hex7 = HEX7_3;
            4'h4: hex7 = HEX7_4;
            4'h5: hex7 = HEX7_5;
            4'h6: hex7 = HEX7_6;
            4'h7: hex7 = HEX7_7;
            4'h8: hex7 = HEX7_8;
            4'h9: hex7 = HEX7_9;
            4'hA: hex7 = HEX7_A;
            4'hB: hex7 = HEX7_B;
            4'hC: hex7 = HEX7_C;
            4'hD: hex7 = HEX7_D;
            4'hE: hex7 = HEX7_E;
            default: hex7 = HEX7_F;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_display_hex7.sv
// Combinational 4-bit hex nibble to seven-segment decoder, one per bank.
module hex7_decode
    import seg_scan_display_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex7(nib);

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment driver: scans N hex digits over several banks that
// share one scan position, with blanking, decimal points, blinking and tear-free loads.
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int NUM_DIGITS      = 8,
    parameter int DIGITS_PER_BANK = 4,
    parameter int CLK_DIV         = 100000,
    parameter int BLINK_FRAMES    = 250
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [4*NUM_DIGITS-1:0]                     data,
    input  logic [NUM_DIGITS-1:0]                       digit_en,
    input  logic [NUM_DIGITS-1:0]                       dp,
    input  logic [NUM_DIGITS-1:0]                       blink,
    input  logic                                        load,
    output logic [NUM_DIGITS-1:0]                       pos,
    output logic [8*(NUM_DIGITS/DIGITS_PER_BANK)-1:0]   seg_code,
    output logic                                        frame_done
);

    localparam int NUM_BANKS = NUM_DIGITS / DIGITS_PER_BANK;
    localparam int TICK_W    = $clog2(CLK_DIV);
    localparam int IDX_W     = (DIGITS_PER_BANK > 1) ? $clog2(DIGITS_PER_BANK) : 1;
    localparam int FRM_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS_PER_BANK - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] data;
        logic [NUM_DIGITS-1:0]   en;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blink;
    } disp_set_t;

    logic [TICK_W-1:0]      tick;
    logic [IDX_W-1:0]       idx;
    logic [FRM_W-1:0]       frame_cnt;
    logic                   blink_phase;
    logic                   step;
    logic                   boundary;
    logic                   pend_valid;
    disp_set_t              pending;
    disp_set_t              shadow;
    disp_set_t              in_set;
    logic [NUM_DIGITS-1:0]  pos_next;
    logic [8*NUM_BANKS-1:0] seg_next;

    assign in_set   = '{data: data, en: digit_en, dp: dp, blink: blink};
    assign step     = (tick == TICK_LAST);
    assign boundary = step && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick        <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            tick <= step ? '0 : tick + 1'b1;
            if (step) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            if (boundary) begin
                frame_cnt <= (frame_cnt == FRM_LAST) ? '0 : frame_cnt + 1'b1;
                if (frame_cnt == FRM_LAST) begin
                    blink_phase <= ~blink_phase;
                end
            end
        end
    end

    // load is a single-cycle strobe with no back-pressure; the latest load before a
    // frame boundary wins, and a load on the boundary cycle bypasses pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending    <= '0;
            shadow     <= '0;
            pend_valid <= 1'b0;
        end else if (load && boundary) begin
            shadow     <= in_set;
            pend_valid <= 1'b0;
        end else if (load) begin
            pending    <= in_set;
            pend_valid <= 1'b1;
        end else if (boundary && pend_valid) begin
            shadow     <= pending;
            pend_valid <= 1'b0;
        end
    end

    always_comb begin
        pos_next = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            pos_next[d] = (idx == IDX_W'(d % DIGITS_PER_BANK));
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [3:0] nib;
        logic       en;
        logic       dpv;
        logic       bl;
        logic [6:0] seg7;
        logic [7:0] seg_bank;

        always_comb begin
            nib = '0;
            en  = 1'b0;
            dpv = 1'b0;
            bl  = 1'b0;
            for (int i = 0; i < DIGITS_PER_BANK; i++) begin
                if (idx == IDX_W'(i)) begin
                    nib = shadow.data[4*(b*DIGITS_PER_BANK+i) +: 4];
                    en  = shadow.en[b*DIGITS_PER_BANK+i];
                    dpv = shadow.dp[b*DIGITS_PER_BANK+i];
                    bl  = shadow.blink[b*DIGITS_PER_BANK+i];
                end
            end
        end

        hex7_decode u_dec (
            .nib (nib),
            .seg (seg7)
        );

        // Blanking clears only the segments; the position strobe keeps scanning.
        always_comb begin
            seg_bank = '0;
            if (en && !(bl && blink_phase)) begin
                seg_bank[SEG_DP]     = dpv;
                seg_bank[SEG_A +: 7] = seg7;
            end
        end

        assign seg_next[8*b +: 8] = seg_bank;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos        <= '0;
            seg_code   <= '0;
            frame_done <= 1'b0;
        end else begin
            pos        <= pos_next;
            seg_code   <= seg_next;
            frame_done <= boundary;
        end
    end

endmodule
